flop_fifo: RTL and testbench
============================

# flop_fifo

Parameterised synchronous FIFO built from flip-flops, used as the buffering block between a producer and a consumer in the verification environment. Words are written with `push`, read in arrival order with `pop`, and status is reported through `full` (no room) and `pndng` (data pending). The head-of-queue word is always presented on `Dout` (first-word fall-through), so a consumer samples `Dout` and asserts `pop` to discard it.

## Interface
- `depth`, default 8: number of storage entries; integer ≥ 2.
- `bits`, default 16: data word width.

- `clk`  input  1: single clock; all state changes on the rising edge.
- `rst`  input  1: reset, asynchronous, active-high.
- `Din`  input  bits: write data, sampled on the `clk` rising edge when `push`=1.
- `push`  input  1: write request.
- `pop`  input  1: read request; removes the head word.
- `Dout`  output  bits: head-of-queue word; 0 when empty.
- `full`  output  1: 1 when occupancy == `depth`.
- `pndng`  output  1: 1 when occupancy ≥ 1.

## Operation
- Storage: `depth` registers of `bits` bits each, plus an occupancy counter of ⌈log2(depth+1)⌉ bits. Either a shift-register or a circular-buffer implementation is acceptable. Read and write pointers, if used, wrap modulo `depth`.
- Reset (`rst`=1, asynchronous):
  - occupancy = 0 and all entries = 0;
  - `Dout`=0, `full`=0, `pndng`=0 immediately, without waiting for a clock edge.
  - Reset asserted mid-operation discards all stored data.
- Each rising edge with `rst`=0, with occupancy n:
  - push only, n < depth: `Din` is appended at the tail; n+1.
  - push only, n == depth: write ignored; contents unchanged; no error flag.
  - pop only, n > 0: head removed; the next word becomes head; n−1.
  - pop only, n == 0: ignored; `Dout` stays 0.
  - push and pop, 0 < n ≤ depth: head removed and `Din` appended in the same cycle; n unchanged. This applies even when full.
  - push and pop, n == 0: treated as push only; the popped value is undefined and must not be relied on.
- Outputs:
  - `Dout` is a combinational read of the head entry, or 0 when n == 0.
  - `full` = (n == depth).
  - `pndng` = (n != 0).
- Ordering: strictly first-in first-out. No data reordering, duplication or loss, except for writes that are ignored while full.

## Timing
- All outputs derive from registered state. They change only after a `clk` rising edge or on `rst` assertion; no output path combinationally depends on `push`, `pop` or `Din`.
- Write latency: a word pushed into an empty FIFO appears on `Dout`, with `pndng`=1, right after that same edge, i.e. visible in the next cycle.
- Pop latency: after a pop edge, `Dout` shows the next word (or 0) in the following cycle.
- `full` asserts after the edge that brings n to `depth`. It deasserts after the first edge with a pop and no push.
- Consumer protocol: sample `Dout` while `pndng`=1, then assert `pop` for one cycle per word consumed.
- Producer protocol: push only while `full`=0, unless pop is asserted in the same cycle.
- Release of `rst` is synchronous-safe: the first operation is taken on the first rising edge after deassertion.

## Test plan
- Reset:
  - Stimulus: assert `rst` between clock edges, mid-stream, with 3 words stored.
  - Required: `Dout`=0, `full`=0, `pndng`=0 immediately. After release, a pop without a prior push leaves `pndng`=0.
- Fill and overflow (depth=8, bits=16):
  - Stimulus: push 0x0001..0x0008, then push 0xBEEF while full.
  - Required: `full`=1 after the 8th edge. Subsequent pops return 0x0001..0x0008 in order and 0xBEEF never appears.
- Underflow:
  - Stimulus: pop on an empty FIFO for 3 cycles.
  - Required: `Dout`=0, `pndng`=0, `full`=0 throughout. A following push of 0x1234 puts 0x1234 on `Dout` after one edge.
- Simultaneous push/pop while full:
  - Stimulus: FIFO full with 0x0010..0x0017; push 0xAAAA and pop together.
  - Required: `full` stays 1, `Dout` becomes 0x0011. Draining yields 0x0011..0x0017 then 0xAAAA.
- Simultaneous push/pop while empty:
  - Stimulus: push 0x5555 with `pop`=1 on an empty FIFO.
  - Required: n=1, `pndng`=1, `Dout`=0x5555.
- Random stress:
  - Stimulus: 10,000 cycles of random `push`/`pop`/`Din`, with reset pulses at random times.
  - Required: output order matches a reference queue model. `full`/`pndng` match the model's occupancy every cycle.

Source files
------------

// File: rtl/flop_fifo_if.sv
// Handshake bundle between a flop_fifo and its producer/consumer.
// The master side drives writes and pops; the slave side is the FIFO itself.
interface flop_fifo_if #(
  parameter int bits = 16
);
  logic [bits-1:0] Din;
  logic            push;
  logic            pop;
  logic [bits-1:0] Dout;
  logic            full;
  logic            pndng;

  modport master (
    output Din, push, pop,
    input  Dout, full, pndng
  );

  modport slave (
    input  Din, push, pop,
    output Dout, full, pndng
  );
endinterface

// File: rtl/flop_fifo.sv
// Flip-flop based circular-buffer FIFO with first-word fall-through output.
// All outputs are decoded from registered state only.
module flop_fifo #(
  parameter int depth = 8,
  parameter int bits  = 16
) (
  input  logic       clk,
  input  logic       rst,
  flop_fifo_if.slave fif
);

  localparam int PTR_W = (depth > 1) ? $clog2(depth) : 1;
  localparam int CNT_W = $clog2(depth + 1);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(depth - 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(depth);

  logic [bits-1:0]  mem_q [depth];
  logic [bits-1:0]  mem_d [depth];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // A pop on an empty FIFO is dropped, and a push while full only lands
  // when the same edge frees the head slot.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    do_pop   = fif.pop && (cnt_q != '0);
    do_push  = fif.push && ((cnt_q != DEPTH_CNT) || do_pop);

    if (do_push) begin
      mem_d[wr_ptr_q] = fif.Din;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end

    if (do_push && !do_pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (do_pop && !do_push) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < depth; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign fif.Dout  = (cnt_q == '0) ? '0 : mem_q[rd_ptr_q];
  assign fif.full  = (cnt_q == DEPTH_CNT);
  assign fif.pndng = (cnt_q != '0);

endmodule

// File: tb/tb_flop_fifo.sv
// Self-checking bench for flop_fifo: directed vector table, hand-written
// corner sequences, and randomized traffic against a queue reference model.
module tb_flop_fifo;

  localparam int DEPTH = 8;
  localparam int BITS  = 16;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  logic [BITS-1:0] model_q[$];

  flop_fifo_if #(.bits(BITS)) fif ();

  flop_fifo #(.depth(DEPTH), .bits(BITS)) dut (
    .clk (clk),
    .rst (rst),
    .fif (fif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic            push;
    logic            pop;
    logic [BITS-1:0] din;
    logic [BITS-1:0] dout;
    logic            full;
    logic            pndng;
  } vec_t;

  vec_t vecs[11];

  // Reference model: a plain queue updated by the FIFO's documented rules.
  task automatic modelStep(input logic p, input logic po, input logic [BITS-1:0] d);
    int  n;
    bit  pop_ok;
    bit  push_ok;
    n       = model_q.size();
    pop_ok  = po && (n > 0);
    push_ok = p && ((n < DEPTH) || pop_ok);
    if (pop_ok) void'(model_q.pop_front());
    if (push_ok) model_q.push_back(d);
  endtask

  // Drive inputs (called just after a falling edge), take one rising edge,
  // then return at the next falling edge where outputs are sampled.
  task automatic applyStimulus(input logic p, input logic po, input logic [BITS-1:0] d);
    fif.push = p;
    fif.pop  = po;
    fif.Din  = d;
    @(posedge clk);
    if (rst) model_q.delete();
    else     modelStep(p, po, d);
    @(negedge clk);
    fif.push = 1'b0;
    fif.pop  = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [BITS-1:0] ed,
                             input logic ef, input logic ep);
    checks++;
    if (fif.Dout !== ed) begin
      errors++;
      $display("[TB] FAIL %s Dout actual=%h required=%h", name, fif.Dout, ed);
    end
    checks++;
    if (fif.full !== ef) begin
      errors++;
      $display("[TB] FAIL %s full actual=%b required=%b", name, fif.full, ef);
    end
    checks++;
    if (fif.pndng !== ep) begin
      errors++;
      $display("[TB] FAIL %s pndng actual=%b required=%b", name, fif.pndng, ep);
    end
  endtask

  task automatic checkModel(input string name);
    logic [BITS-1:0] ed;
    ed = (model_q.size() > 0) ? model_q[0] : '0;
    checkOutput(name, ed, model_q.size() == DEPTH, model_q.size() != 0);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_q.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    errors   = 0;
    checks   = 0;
    rst      = 1'b1;
    fif.push = 1'b0;
    fif.pop  = 1'b0;
    fif.Din  = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset_state", 16'h0000, 1'b0, 1'b0);
    rst = 1'b0;

    // Directed vector table starting from empty.
    vecs[0]  = '{1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 16'h1234, 16'h1234, 1'b0, 1'b1};
    vecs[4]  = '{1'b1, 1'b0, 16'h5678, 16'h1234, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, 1'b1, 16'h9ABC, 16'h5678, 1'b0, 1'b1};
    vecs[6]  = '{1'b0, 1'b1, 16'h0000, 16'h9ABC, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 16'h5555, 16'h5555, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 16'hFFFF, 16'h0000, 1'b0, 1'b0};
    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].push, vecs[i].pop, vecs[i].din);
      checkOutput($sformatf("vec%0d", i), vecs[i].dout, vecs[i].full, vecs[i].pndng);
    end

    // Asynchronous reset between edges with three words stored.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 16'h0A00 + 16'(i));
    checkOutput("pre_reset", 16'h0A00, 1'b0, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_reset", 16'h0000, 1'b0, 1'b0);
    model_q.delete();
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b0, 1'b1, 16'h0000);
    checkOutput("pop_after_reset", 16'h0000, 1'b0, 1'b0);

    // Fill and overflow.
    for (int i = 1; i <= DEPTH; i++) begin
      applyStimulus(1'b1, 1'b0, 16'(i));
      checkOutput($sformatf("fill%0d", i), 16'h0001, i == DEPTH, 1'b1);
    end
    applyStimulus(1'b1, 1'b0, 16'hBEEF);
    checkOutput("overflow", 16'h0001, 1'b1, 1'b1);
    for (int i = 1; i <= DEPTH; i++) begin
      checkOutput($sformatf("drain%0d", i), 16'(i), i == 1, 1'b1);
      applyStimulus(1'b0, 1'b1, 16'h0000);
    end
    checkOutput("drained", 16'h0000, 1'b0, 1'b0);

    // Simultaneous push and pop while full.
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 1'b0, 16'h0010 + 16'(i));
    checkOutput("full_again", 16'h0010, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1, 16'hAAAA);
    checkOutput("full_pushpop", 16'h0011, 1'b1, 1'b1);
    for (int i = 1; i < DEPTH; i++) begin
      checkOutput($sformatf("fdrain%0d", i), 16'h0010 + 16'(i), i == 1, 1'b1);
      applyStimulus(1'b0, 1'b1, 16'h0000);
    end
    checkOutput("fdrain_last", 16'hAAAA, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 16'h0000);
    checkOutput("fdrain_empty", 16'h0000, 1'b0, 1'b0);

    // Randomized traffic with occasional reset pulses, phased push bias.
    doReset();
    for (int c = 0; c < 10000; c++) begin
      int pct;
      logic p;
      logic po;
      pct = ((c / 400) % 2 == 0) ? 75 : 30;
      p   = ($urandom_range(99) < pct);
      po  = ($urandom_range(99) < 50);
      if ($urandom_range(299) == 0) rst = 1'b1;
      applyStimulus(p, po, 16'($urandom));
      rst = 1'b0;
      checkModel($sformatf("rand%0d", c));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
